// File: rtl/sram_datain_poller.sv
// rtl/sram_datain_poller.sv - periodic 8-bit input-port poller with change-filtered sample FIFO
module sram_datain_poller #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READ, ST_CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        first_flag_q, first_flag_d;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  last_value_q, last_value_d;
    logic [31:0] s_readdata_q, s_readdata_d;

    logic [7:0]  sample;
    logic        full, not_empty, push_req, push_ok, pop, ovf_event;
    logic [31:0] status_w;
    logic        unused_bits;

    assign sample      = m_readdata[7:0];
    assign full        = (count_q == 3'd4);
    assign not_empty   = (count_q != 3'd0);
    assign push_req    = (state_q == ST_CAPTURE) && (first_flag_q || (sample != last_value_q));
    assign pop         = s_read && (s_address == 2'd2) && not_empty;
    // A same-cycle pop frees the slot the push needs, so only an unpopped full FIFO overflows.
    assign push_ok     = push_req && (!full || pop);
    assign ovf_event   = push_req && full && !pop;
    assign status_w    = {16'h0, last_value_q, 1'b0, count_q, 1'b0, overflow_q, full, not_empty};
    assign unused_bits = ^{m_readdata[31:8], s_writedata[31:16]};

    assign m_address  = 2'b00;
    assign m_read     = (state_q == ST_READ) && enable_q;
    assign s_readdata = s_readdata_q;
    assign irq        = irq_en_q && (not_empty || overflow_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_flag_d = first_flag_q;
        last_value_d = last_value_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d      = ST_WAIT;
                    cnt_d        = period_q;
                    first_flag_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!enable_q)             state_d = ST_IDLE;
                else if (cnt_q == 16'd0)   state_d = ST_READ;
                else                       cnt_d   = cnt_q - 16'd1;
            end
            ST_READ: state_d = enable_q ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: begin
                last_value_d = sample;
                first_flag_d = 1'b0;
                if (enable_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = period_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enable_d     = enable_q;
        irq_en_d     = irq_en_q;
        period_d     = period_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        s_readdata_d = s_readdata_q;
        count_d      = count_q + {2'b00, push_ok} - {2'b00, pop};

        if (push_ok) begin
            mem_d[wr_ptr_q] = sample;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

        if (s_write) begin
            case (s_address)
                2'd0:    begin enable_d = s_writedata[0]; irq_en_d = s_writedata[1]; end
                2'd1:    period_d = s_writedata[15:0];
                default: ;
            endcase
        end

        if (ovf_event)                                           overflow_d = 1'b1;
        else if (s_write && (s_address == 2'd3) && s_writedata[2]) overflow_d = 1'b0;

        if (s_read) begin
            case (s_address)
                2'd0:    s_readdata_d = {30'h0, irq_en_q, enable_q};
                2'd1:    s_readdata_d = {16'h0, period_q};
                2'd2:    s_readdata_d = not_empty ? {23'h0, 1'b1, mem_q[rd_ptr_q]} : 32'h0;
                default: s_readdata_d = status_w;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            first_flag_q <= 1'b0;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            period_q     <= DEFAULT_PERIOD;
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            overflow_q   <= 1'b0;
            last_value_q <= 8'h0;
            s_readdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_flag_q <= first_flag_d;
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            period_q     <= period_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            last_value_q <= last_value_d;
            s_readdata_q <= s_readdata_d;
        end
    end

endmodule

// File: tb/tb_sram_datain_poller.sv
// tb/tb_sram_datain_poller.sv - directed self-checking bench for sram_datain_poller
module tb_sram_datain_poller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic [1:0]  s_address = 2'd0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = 32'h0;
    logic [31:0] s_readdata;
    logic        irq;
    logic [7:0]  in_val = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mread_cnt = 0;

    assign m_readdata = {24'h0, in_val};

    sram_datain_poller #(.DEFAULT_PERIOD(16'd1000)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_read) mread_cnt <= mread_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_address = addr; s_writedata = data; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        s_address = addr; s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        data = s_readdata;
    endtask

    task automatic wait_mread(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_read) begin ok = 1'b1; break; end
        end
        check(tag, {31'h0, ok}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int t0;
        int snap;

        repeat (3) @(negedge clk);
        check("reset_m_read", {31'h0, m_read}, 32'd0);
        check("reset_irq", {31'h0, irq}, 32'd0);
        check("reset_s_readdata", s_readdata, 32'h0);
        check("m_address", {30'h0, m_address}, 32'd0);
        reset_n = 1'b1;
        cpu_read(2'd0, rd); check("reset_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); check("reset_period", rd, 32'd1000);
        cpu_read(2'd3, rd); check("reset_status", rd, 32'h0);
        cpu_read(2'd2, rd); check("reset_data_empty", rd, 32'h0);

        // Constant input: one push only, 5-cycle sample interval.
        cpu_write(2'd1, 32'd2);
        cpu_read(2'd1, rd); check("period_rb", rd, 32'd2);
        in_val = 8'h5A;
        cpu_write(2'd0, 32'd1);
        wait_mread("mread_5a_first", 30);
        t0 = cyc;
        wait_mread("mread_5a_second", 30);
        check("interval", cyc - t0, 32'd5);
        cpu_write(2'd0, 32'd0);
        snap = mread_cnt;
        repeat (20) @(negedge clk);
        check("no_mread_after_disable", mread_cnt, snap);
        cpu_read(2'd3, rd); check("status_5a", rd, 32'h0000_5A11);
        cpu_read(2'd2, rd); check("data_5a", rd, 32'h15A);
        repeat (3) @(negedge clk);
        check("s_readdata_hold", s_readdata, 32'h15A);
        cpu_read(2'd2, rd); check("data_empty", rd, 32'h0);

        // Re-enable with the same value: first sample still pushed.
        cpu_write(2'd0, 32'd1);
        wait_mread("mread_reenable", 30);
        repeat (2) @(negedge clk);
        cpu_write(2'd0, 32'd0);
        cpu_read(2'd3, rd); check("status_reenable", rd, 32'h0000_5A11);
        cpu_read(2'd2, rd); check("data_reenable", rd, 32'h15A);

        // Changing input overfills the FIFO.
        in_val = 8'h01;
        cpu_write(2'd0, 32'd1);
        for (int v = 1; v <= 5; v++) begin
            wait_mread("mread_fill", 30);
            repeat (2) @(negedge clk);
            in_val = 8'(v + 1);
        end
        cpu_write(2'd0, 32'd0);
        cpu_read(2'd3, rd); check("status_full_ovf", rd, 32'h0000_0547);
        cpu_write(2'd3, 32'h4);
        cpu_read(2'd3, rd); check("status_w1c", rd, 32'h0000_0543);

        // Pop coinciding with the capture push while full.
        cpu_write(2'd0, 32'd1);
        wait_mread("mread_pushpop", 30);
        cpu_read(2'd2, rd); check("pushpop_data", rd, 32'h101);
        cpu_write(2'd0, 32'd0);
        cpu_read(2'd3, rd); check("status_pushpop", rd, 32'h0000_0643);
        cpu_read(2'd2, rd); check("pop_02", rd, 32'h102);
        cpu_read(2'd2, rd); check("pop_03", rd, 32'h103);
        cpu_read(2'd2, rd); check("pop_04", rd, 32'h104);
        cpu_read(2'd2, rd); check("pop_06", rd, 32'h106);
        cpu_read(2'd2, rd); check("pop_empty", rd, 32'h0);

        // Interrupt follows FIFO occupancy.
        in_val = 8'h07;
        cpu_write(2'd0, 32'd3);
        check("irq_idle_empty", {31'h0, irq}, 32'd0);
        wait_mread("mread_irq", 30);
        @(negedge clk);
        check("irq_before_push", {31'h0, irq}, 32'd0);
        @(negedge clk);
        check("irq_after_push", {31'h0, irq}, 32'd1);
        cpu_write(2'd0, 32'd2);
        check("irq_held", {31'h0, irq}, 32'd1);
        cpu_read(2'd2, rd); check("irq_data", rd, 32'h107);
        check("irq_after_pop", {31'h0, irq}, 32'd0);

        // Reset during READ.
        in_val = 8'h08;
        cpu_write(2'd0, 32'd3);
        wait_mread("mread_rst_first", 30);
        repeat (2) @(negedge clk);
        check("irq_pre_reset", {31'h0, irq}, 32'd1);
        wait_mread("mread_rst_second", 30);
        reset_n = 1'b0;
        #1;
        check("rst_m_read", {31'h0, m_read}, 32'd0);
        check("rst_irq", {31'h0, irq}, 32'd0);
        check("rst_s_readdata", s_readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        snap = mread_cnt;
        repeat (20) @(negedge clk);
        check("rst_no_mread", mread_cnt, snap);
        cpu_read(2'd3, rd); check("rst_status", rd, 32'h0);
        cpu_read(2'd0, rd); check("rst_ctrl", rd, 32'h0);
        cpu_read(2'd1, rd); check("rst_period", rd, 32'd1000);
        cpu_read(2'd2, rd); check("rst_data", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_datain_poller.md
SRAM_DATAIN_POLLER -- requirements
Module: sram_datain_poller

Interface
REQ-001 Parameter DEFAULT_PERIOD, default 16'd1000, reset value of the PERIOD register.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 m_address  output  2  master address to the 8-bit input-port slave; constant 2'b00.
REQ-005 m_read  output  1  master read strobe, one cycle per sample.
REQ-006 m_readdata  input  32  slave read data, valid the cycle after m_read; only bits [7:0] used.
REQ-007 s_address  input  2  CPU register select.
REQ-008 s_read  input  1  CPU read strobe.
REQ-009 s_write  input  1  CPU write strobe.
REQ-010 s_writedata  input  32  CPU write data.
REQ-011 s_readdata  output  32  CPU read data, registered, 1-cycle latency.
REQ-012 irq  output  1  interrupt, active-high level.

Function
REQ-013 Register map: 0 CTRL (RW): bit0 enable, bit1 irq_en; 1 PERIOD (RW) [15:0]; 2 DATA (RO, pop); 3 STATUS (RO, W1C on bit2).
REQ-014 STATUS: bit0 not_empty, bit1 full, bit2 overflow (sticky), [6:4] count (0-4), [15:8] last_value; other bits 0.
REQ-015 DATA read: FIFO non-empty -> {23'b0, 1'b1, head[7:0]}, pop; empty -> 32'h0, no state change.
REQ-016 s_readdata updates only on s_read cycles and holds otherwise; unmapped bits read 0.
REQ-017 FSM states: IDLE, WAIT, READ, CAPTURE.
REQ-018 IDLE: enable=1 -> WAIT, loading cnt=PERIOD and setting first_flag=1.
REQ-019 WAIT: cnt==0 -> READ; else cnt decrements; WAIT lasts PERIOD+1 cycles; sample interval PERIOD+3 cycles.
REQ-020 READ: m_read=1 for exactly this cycle -> CAPTURE.
REQ-021 CAPTURE: sample=m_readdata[7:0]; if first_flag or sample!=last_value -> push sample; last_value<=sample; first_flag<=0; -> WAIT (reload cnt) if enable else IDLE.
REQ-022 m_read is 0 in all states other than READ.
REQ-023 enable=0 in WAIT or READ -> IDLE next cycle, no m_read/no push; CAPTURE always completes.
REQ-024 FIFO: 4 entries x 8 bits, circular pointers wrap 3->0.
REQ-025 Push when full: sample dropped, FIFO unchanged, overflow<=1; last_value still updates.
REQ-026 Push and pop in same cycle: both occur, count unchanged; when full, simultaneous pop frees space so push succeeds, no overflow.
REQ-027 Write 1 to STATUS bit2 clears overflow; a same-cycle overflow event takes priority (overflow stays 1).
REQ-028 PERIOD write during WAIT takes effect at next cnt load only.
REQ-029 irq = irq_en & (not_empty | overflow), from registered state, no pulse stretching.

Reset
REQ-030 On reset_n=0: FSM=IDLE, m_read=0, s_readdata=0, irq=0, CTRL=0, PERIOD=DEFAULT_PERIOD, FIFO empty, count=0, overflow=0, last_value=0, first_flag=0, cnt=0.
REQ-031 Reset asserted mid-READ/CAPTURE aborts immediately; in-flight sample discarded.

Verification
REQ-032 PERIOD=2, enable, in_port constant 8'h5A -> m_read every 5 cycles; exactly one push (first sample); DATA read returns 32'h15A, then 32'h0.
REQ-033 in_port 8'h01,02,03,04,05 changing each interval, no pops -> 4 entries 01-04, full=1, overflow=1, STATUS[15:8]=8'h05; W1C bit2 -> overflow=0.
REQ-034 FIFO full, DATA read in same cycle as CAPTURE push of new value -> count stays 4, overflow=0, next pops 02,03,04,new.
REQ-035 irq_en=1, one push -> irq=1 the cycle after push; pop last entry -> irq=0 the cycle after read.
REQ-036 Clear enable during WAIT -> IDLE next cycle, no further m_read; re-enable -> first sample pushed even if equal to last_value.
REQ-037 reset_n low during READ -> all outputs/registers at REQ-030 values, no push after release.
